mouse_pointer: RTL and testbench

Downstream consumer of the PS/2 mouse packet decoder. Takes each decoded packet (9-bit two's-complement dx/dy plus buttons, qualified by a one-cycle data_ready pulse) and accumulates it into an absolute, clamped screen pointer position. Tracks button state and sticky press events, and exposes position and status through a small CPU read port with a change interrupt.

---
 rtl/mouse_pkg.sv | 24 ++
 rtl/mouse_pointer_if.sv | 27 ++
 rtl/mouse_axis_acc.sv | 43 ++++
 rtl/mouse_pointer.sv | 86 ++++++++
 tb/tb_mouse_pointer.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mouse_pkg.sv
// mouse_pkg: shared register map, status bit layout and default geometry for mouse_pointer.
package mouse_pkg;
    localparam logic [1:0] REG_X      = 2'd0;
    localparam logic [1:0] REG_Y      = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam int ST_LEFT     = 0;
    localparam int ST_RIGHT    = 1;
    localparam int ST_STICKY_L = 2;
    localparam int ST_STICKY_R = 3;
    localparam int ST_CHANGED  = 6;
    localparam int DEF_MAX_X    = 511;
    localparam int DEF_MAX_Y    = 255;
    localparam int DEF_SHIFT    = 0;
    localparam bit DEF_INVERT_Y = 1'b1;

    function automatic logic [15:0] status_word(logic changed, logic [1:0] sticky, logic [1:0] btn);
        logic [15:0] s;
        s = '0;
        s[ST_CHANGED] = changed;
        s[ST_STICKY_R:ST_STICKY_L] = sticky;
        s[ST_RIGHT:ST_LEFT] = btn;
        return s;
    endfunction
endpackage

// File: rtl/mouse_pointer_if.sv
// mouse_pointer_if: decoded-packet input, CPU read port and pointer state outputs.
interface mouse_pointer_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          data_ready;
    logic          left_btn;
    logic          right_btn;
    logic [8:0]    pointer_dx;
    logic [8:0]    pointer_dy;
    logic          rd_strobe;
    logic [1:0]    rd_sel;
    logic [15:0]   rd_data;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic [1:0]    btn;
    logic          irq;

    modport master (
        output data_ready, left_btn, right_btn, pointer_dx, pointer_dy, rd_strobe, rd_sel,
        input  rd_data, pos_x, pos_y, btn, irq
    );
    modport slave (
        input  data_ready, left_btn, right_btn, pointer_dx, pointer_dy, rd_strobe, rd_sel,
        output rd_data, pos_x, pos_y, btn, irq
    );
endinterface

// File: rtl/mouse_axis_acc.sv
// mouse_axis_acc: one pointer axis -- scale/sign the 9-bit delta, then accumulate with clamping to 0..MAX.
module mouse_axis_acc #(
    parameter int W      = 10,
    parameter int MAX    = 511,
    parameter int SHIFT  = 0,
    parameter bit INVERT = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         v0,
    input  logic         v1,
    input  logic [8:0]   d,
    output logic [W-1:0] pos,
    output logic         moved
);
    localparam logic signed [W+1:0] MAX_S = (W+2)'(MAX);

    logic signed [W:0]   ext, sh, delta_q, delta_d;
    logic signed [W+1:0] sum;
    logic [W-1:0]        pos_q, pos_d;

    // Extend before negating so -256 inverts to +256 without wrapping.
    always_comb begin
        ext     = {{(W-8){d[8]}}, d};
        sh      = ext >>> SHIFT;
        delta_d = v0 ? (INVERT ? -sh : sh) : delta_q;
        sum     = $signed({2'b00, pos_q}) + $signed({delta_q[W], delta_q});
        pos_d   = !v1 ? pos_q : sum[W+1] ? '0 : (sum > MAX_S) ? W'(MAX) : sum[W-1:0];
        moved   = v1 && (pos_d != pos_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delta_q <= '0;
            pos_q   <= W'((MAX + 1) / 2);
        end else begin
            delta_q <= delta_d;
            pos_q   <= pos_d;
        end
    end

    assign pos = pos_q;
endmodule

// File: rtl/mouse_pointer.sv
// mouse_pointer: turns decoded PS/2 packets into a clamped absolute pointer with button
// tracking, sticky press events, a CPU read port and a change interrupt.
module mouse_pointer
    import mouse_pkg::*;
#(
    parameter int MAX_X    = DEF_MAX_X,
    parameter int MAX_Y    = DEF_MAX_Y,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int SHIFT    = DEF_SHIFT,
    parameter bit INVERT_Y = DEF_INVERT_Y
) (
    input logic             clk,
    input logic             reset,
    mouse_pointer_if.slave  bus
);
    logic          v0_q, v0_d, v1_q, v1_d;
    logic [8:0]    dx0_q, dx0_d, dy0_q, dy0_d;
    logic [1:0]    btn0_q, btn0_d, btn1_q, btn1_d, btn_q, btn_d;
    logic [1:0]    sticky_q, sticky_d;
    logic          changed_q, changed_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic          moved_x, moved_y, set, clr;
    logic [1:0]    rise;

    mouse_axis_acc #(.W(XW), .MAX(MAX_X), .SHIFT(SHIFT), .INVERT(1'b0)) u_x (
        .clk(clk), .reset(reset), .v0(v0_q), .v1(v1_q), .d(dx0_q), .pos(pos_x), .moved(moved_x)
    );
    mouse_axis_acc #(.W(YW), .MAX(MAX_Y), .SHIFT(SHIFT), .INVERT(INVERT_Y)) u_y (
        .clk(clk), .reset(reset), .v0(v0_q), .v1(v1_q), .d(dy0_q), .pos(pos_y), .moved(moved_y)
    );

    // A flag set in the same cycle as a status read survives the read-clear.
    always_comb begin
        v0_d      = bus.data_ready;
        dx0_d     = bus.data_ready ? bus.pointer_dx : dx0_q;
        dy0_d     = bus.data_ready ? bus.pointer_dy : dy0_q;
        btn0_d    = bus.data_ready ? {bus.right_btn, bus.left_btn} : btn0_q;
        v1_d      = v0_q;
        btn1_d    = v0_q ? btn0_q : btn1_q;
        btn_d     = v1_q ? btn1_q : btn_q;
        rise      = v1_q ? (btn1_q & ~btn_q) : 2'b00;
        set       = moved_x || moved_y || (v1_q && (btn1_q != btn_q));
        clr       = bus.rd_strobe && (bus.rd_sel == REG_STATUS);
        changed_d = set || (changed_q && !clr);
        sticky_d  = rise | (sticky_q & {2{!clr}});
        rd_data_d = !bus.rd_strobe ? rd_data_q :
                    (bus.rd_sel == REG_X) ? 16'(pos_x) :
                    (bus.rd_sel == REG_Y) ? 16'(pos_y) :
                    (bus.rd_sel == REG_STATUS) ? status_word(changed_q, sticky_q, btn_q) : 16'h0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            dx0_q     <= '0;
            dy0_q     <= '0;
            btn0_q    <= '0;
            btn1_q    <= '0;
            btn_q     <= '0;
            sticky_q  <= '0;
            changed_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            dx0_q     <= dx0_d;
            dy0_q     <= dy0_d;
            btn0_q    <= btn0_d;
            btn1_q    <= btn1_d;
            btn_q     <= btn_d;
            sticky_q  <= sticky_d;
            changed_q <= changed_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.pos_x   = pos_x;
    assign bus.pos_y   = pos_y;
    assign bus.btn     = btn_q;
    assign bus.irq     = changed_q;
endmodule

// File: tb/tb_mouse_pointer.sv
// tb_mouse_pointer: directed packets and reads on two instances (SHIFT=0 and SHIFT=1) checked against a scoreboard.
module tb_mouse_pointer;
  import mouse_pkg::*;
  typedef enum int {S_RD, S_PX, S_PY, S_BTN, S_IRQ} sig_e;
  typedef struct {
    int          d;
    sig_e        s;
    logic [15:0] val;
    int          at;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mouse_pointer_if #(.XW(10), .YW(9)) bus0 ();
  mouse_pointer_if #(.XW(10), .YW(9)) bus1 ();
  mouse_pointer #(.SHIFT(0)) u0 (.clk(clk), .reset(reset), .bus(bus0));
  mouse_pointer #(.SHIFT(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));
  function automatic logic [15:0] get(int d, sig_e s);
    case (s)
      S_RD:    return d != 0 ? bus1.rd_data : bus0.rd_data;
      S_PX:    return 16'(d != 0 ? bus1.pos_x : bus0.pos_x);
      S_PY:    return 16'(d != 0 ? bus1.pos_y : bus0.pos_y);
      S_BTN:   return 16'(d != 0 ? bus1.btn : bus0.btn);
      default: return 16'(d != 0 ? bus1.irq : bus0.irq);
    endcase
  endfunction
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      logic [15:0] act;
      e = sb.pop_front();
      act = get(e.d, e.s);
      checks++;
      if (act !== e.val) begin
        errs++;
        $display("FAIL dut%0d %s at cycle %0d: got 0x%04h, want 0x%04h", e.d, e.s.name(), cyc, act, e.val);
      end
    end
  end
  task automatic drv(int d, logic dr, logic [8:0] dx, logic [8:0] dy, logic l, logic r, logic st, logic [1:0] sel);
    @(negedge clk);
    bus0.data_ready = dr && d == 0;
    bus1.data_ready = dr && d == 1;
    bus0.rd_strobe  = st && d == 0;
    bus1.rd_strobe  = st && d == 1;
    {bus0.pointer_dx, bus0.pointer_dy, bus0.left_btn, bus0.right_btn, bus0.rd_sel} = {dx, dy, l, r, sel};
    {bus1.pointer_dx, bus1.pointer_dy, bus1.left_btn, bus1.right_btn, bus1.rd_sel} = {dx, dy, l, r, sel};
  endtask
  task automatic tick();
    drv(0, 1'b0, 9'h0, 9'h0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask
  task automatic pkt(int d, logic [8:0] dx, logic [8:0] dy, logic l, logic r);
    drv(d, 1'b1, dx, dy, l, r, 1'b0, 2'd0);
  endtask
  task automatic ex(int d, sig_e s, logic [15:0] v);
    sb.push_back('{d, s, v, cyc + 1});
  endtask
  task automatic rd(int d, logic [1:0] sel, logic [15:0] v);
    drv(d, 1'b0, 9'h0, 9'h0, 1'b0, 1'b0, 1'b1, sel);
    ex(d, S_RD, v);
  endtask
  task automatic settle();
    tick();
    tick();
  endtask
  initial begin
    tick();
    checks++;
    if (bus0.pos_x !== 10'd256 || bus0.pos_y !== 9'd128 || bus0.btn !== 2'b00 || bus0.irq !== 1'b0 ||
        bus1.pos_x !== 10'd256 || bus1.pos_y !== 9'd128 || bus1.btn !== 2'b00 || bus1.irq !== 1'b0) begin
      errs++;
      $display("FAIL reset state: pos_x=%0d pos_y=%0d btn=%b irq=%b", bus0.pos_x, bus0.pos_y, bus0.btn, bus0.irq);
    end
    ex(0, S_PX, 16'd256); ex(0, S_PY, 16'd128); ex(0, S_BTN, 16'd0); ex(0, S_IRQ, 16'd0);
    tick();
    reset = 1'b0;
    rd(0, REG_STATUS, 16'h0000);
    rd(0, REG_X, 16'd256);
    rd(0, 2'd3, 16'h0000);
    pkt(0, 9'h00A, 9'h005, 1'b0, 1'b0);
    tick();
    ex(0, S_PX, 16'd256);
    tick();
    ex(0, S_PX, 16'd266); ex(0, S_PY, 16'd123); ex(0, S_IRQ, 16'd1);
    tick();
    rd(0, REG_STATUS, 16'h0040);
    ex(0, S_IRQ, 16'd0);
    for (int i = 0; i < 10; i++) pkt(0, 9'h100, 9'h000, 1'b0, 1'b0);
    settle();
    ex(0, S_PX, 16'd0);
    tick();
    pkt(0, 9'h000, 9'h100, 1'b0, 1'b0);
    pkt(0, 9'h000, 9'h100, 1'b0, 1'b0);
    settle();
    ex(0, S_PY, 16'd255); ex(0, S_PX, 16'd0);
    tick();
    rd(0, REG_Y, 16'd255);
    rd(0, REG_STATUS, 16'h0040);
    pkt(0, 9'h000, 9'h000, 1'b1, 1'b0);
    settle();
    ex(0, S_BTN, 16'd1);
    tick();
    rd(0, REG_STATUS, 16'h0045);
    pkt(0, 9'h000, 9'h000, 1'b0, 1'b0);
    settle();
    ex(0, S_BTN, 16'd0);
    tick();
    rd(0, REG_STATUS, 16'h0040);
    pkt(0, 9'h000, 9'h000, 1'b1, 1'b0);
    pkt(0, 9'h000, 9'h000, 1'b0, 1'b0);
    settle();
    ex(0, S_BTN, 16'd0);
    tick();
    rd(0, REG_STATUS, 16'h0044);
    rd(0, REG_STATUS, 16'h0000);
    pkt(0, 9'h000, 9'h000, 1'b0, 1'b1);
    settle();
    ex(0, S_BTN, 16'd2);
    tick();
    rd(0, REG_STATUS, 16'h004A);
    pkt(0, 9'h000, 9'h000, 1'b0, 1'b0);
    settle();
    tick();
    rd(0, REG_STATUS, 16'h0040);
    pkt(0, 9'h000, 9'h000, 1'b0, 1'b0);
    settle();
    ex(0, S_IRQ, 16'd0); ex(0, S_PX, 16'd0); ex(0, S_PY, 16'd255);
    tick();
    rd(0, REG_STATUS, 16'h0000);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    pkt(0, 9'h001, 9'h000, 1'b0, 1'b0);
    pkt(0, 9'h002, 9'h000, 1'b0, 1'b0);
    pkt(0, 9'h003, 9'h000, 1'b0, 1'b0);
    tick();
    rd(0, REG_STATUS, 16'h0040);
    ex(0, S_IRQ, 16'd1); ex(0, S_PX, 16'd262);
    rd(0, REG_STATUS, 16'h0040);
    ex(0, S_IRQ, 16'd0);
    pkt(1, 9'h1FF, 9'h1FD, 1'b0, 1'b0);
    settle();
    ex(1, S_PX, 16'd255); ex(1, S_PY, 16'd130); ex(1, S_IRQ, 16'd1);
    tick();
    rd(1, REG_STATUS, 16'h0040);
    ex(1, S_IRQ, 16'd0);
    pkt(1, 9'h001, 9'h000, 1'b0, 1'b0);
    settle();
    ex(1, S_PX, 16'd255); ex(1, S_IRQ, 16'd0);
    tick();
    pkt(1, 9'h064, 9'h000, 1'b0, 1'b0);
    @(negedge clk) begin
      reset = 1'b1;
      bus1.data_ready = 1'b0;
    end
    @(negedge clk) reset = 1'b0;
    settle();
    ex(1, S_PX, 16'd256); ex(1, S_PY, 16'd128); ex(1, S_IRQ, 16'd0);
    tick();
    rd(1, REG_X, 16'd256);
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    tick();
    checks++;
    if (sb.size() > 0) begin
      errs++;
      $display("FAIL timeout: %0d expectations never checked", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
